// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the four-channel TDM demultiplexer.
// Holds the lock FSM encoding and the slot/channel sizing constants.
package tdm_demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// Modulo-4 slot counter for the TDM demultiplexer.
// A load forces slot 1 (the slot after a sync sample); enable steps it.
module tdm_slot_ctr
    import tdm_demux4_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  en,
    output slot_t slot
);

    // Load wins over enable; natural 2-bit overflow gives the 3->0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load) begin
            slot <= slot_t'(1);
        end else if (en) begin
            slot <= slot + slot_t'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel time-division demultiplexer: locks onto the sync-marked
// slot rotation and steers each sample into a held per-channel register.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sync,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    output logic                    frame_valid,
    output logic                    locked,
    output logic                    sync_err
);

    state_t            state, state_nxt;
    slot_t             slot;
    logic              ctr_load, ctr_en;
    logic [NUM_CH-1:0] wr_mask;
    logic              frame_ok, frame_ok_nxt;
    logic              frame_nxt, err_nxt;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ctr_load),
        .en    (ctr_en),
        .slot  (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // A sync sample always opens a fresh frame with channel 0, so every
    // path that writes channel 0 on sync reloads the slot counter to 1.
    always_comb begin
        state_nxt    = state;
        ctr_load     = 1'b0;
        ctr_en       = 1'b0;
        wr_mask      = '0;
        frame_ok_nxt = frame_ok;
        frame_nxt    = 1'b0;
        err_nxt      = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    if (in_sync) begin
                        wr_mask[0]   = 1'b1;
                        ctr_load     = 1'b1;
                        frame_ok_nxt = 1'b1;
                        state_nxt    = LOCK;
                    end
                end
                LOCK: begin
                    if (in_sync && slot != slot_t'(0)) begin
                        err_nxt      = 1'b1;
                        wr_mask[0]   = 1'b1;
                        ctr_load     = 1'b1;
                        frame_ok_nxt = 1'b1;
                    end else if (!in_sync && slot == slot_t'(0)) begin
                        err_nxt      = 1'b1;
                        frame_ok_nxt = 1'b0;
                        state_nxt    = HUNT;
                    end else begin
                        wr_mask[slot] = 1'b1;
                        ctr_en        = 1'b1;
                        if (slot == slot_t'(0)) begin
                            frame_ok_nxt = 1'b1;
                        end
                        if (slot == slot_t'(NUM_CH-1)) begin
                            frame_nxt = frame_ok;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_valid   <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            frame_ok    <= 1'b0;
        end else begin
            out_valid   <= wr_mask;
            frame_valid <= frame_nxt;
            sync_err    <= err_nxt;
            frame_ok    <= frame_ok_nxt;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_mask[k]) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                end
            end
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 at WIDTH=8: a directed vector table
// followed by hand-written reset sequences.
module tb_tdm_demux4;

    localparam int W = 8;

    typedef struct packed {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [31:0] data;
        logic [3:0]  ov;
        logic        fv;
        logic        lk;
        logic        err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_sync;
    logic [W-1:0]  in_data;
    logic [4*W-1:0] out_data;
    logic [3:0]    out_valid;
    logic          frame_valid;
    logic          locked;
    logic          sync_err;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs [28];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .in_data     (in_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] data, input logic [3:0] ov,
                               input logic fv, input logic lk, input logic err);
        checkField({tag, ".out_data"}, out_data, data);
        checkField({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        checkField({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
        checkField({tag, ".locked"}, 32'(locked), 32'(lk));
        checkField({tag, ".sync_err"}, 32'(sync_err), 32'(err));
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'hA1, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'hA2, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'hA3, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h11, 32'h00000011, 4'h1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h22, 32'h00002211, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h33, 32'h00332211, 4'h4, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h44, 32'h44332211, 4'h8, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'h55, 32'h44332255, 4'h1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'hEE, 32'h44332255, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h66, 32'h44336655, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'hEE, 32'h44336655, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'hEE, 32'h44336655, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'h77, 32'h44776655, 4'h4, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h88, 32'h88776655, 4'h8, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 8'h01, 32'h88776601, 4'h1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 8'h02, 32'h88770201, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 8'h03, 32'h88770203, 4'h1, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 8'h04, 32'h88770403, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 8'h05, 32'h88050403, 4'h4, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 8'h06, 32'h06050403, 4'h8, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 8'h09, 32'h06050403, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{1'b1, 1'b1, 8'h0A, 32'h0605040A, 4'h1, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 8'hEE, 32'h0605040A, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 8'h0B, 32'h06050B0A, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 8'h0C, 32'h060C0B0A, 4'h4, 1'b0, 1'b1, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 8'h0D, 32'h0D0C0B0A, 4'h8, 1'b1, 1'b1, 1'b0};
        vecs[26] = '{1'b1, 1'b1, 8'h31, 32'h0D0C0B31, 4'h1, 1'b0, 1'b1, 1'b0};
        vecs[27] = '{1'b1, 1'b0, 8'h32, 32'h0D0C3231, 4'h2, 1'b0, 1'b1, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("in_reset", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("idle%0d", i), 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i].v, vecs[i].s, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].data, vecs[i].ov,
                        vecs[i].fv, vecs[i].lk, vecs[i].err);
        end

        // Channels 0 and 1 of a frame are written; reset lands between edges.
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_held", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h41);
        checkOutput("post_reset_nosync", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h42);
        checkOutput("post_reset_nosync2", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h51);
        checkOutput("post_reset_relock", 32'h00000051, 4'h1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h52);
        checkOutput("post_reset_ch1", 32'h00005251, 4'h2, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
